dbus_slow_peri_bridge: RTL and testbench

//  Registered request/acknowledge bridge that sits directly downstream of the data-bus interconnect.
//  It sits in front of one multi-cycle peripheral (SPI, GPIO, ...).
//  It latches a selected dbus request and re-issues it to the peripheral as a held req/ack handshake.
//  It returns read data plus a one-cycle ack to the interconnect's peri2dbus mux input.
//  An optional watchdog terminates hung transfers with an error response.

---
 rtl/dbus_slow_peri_bridge_pkg.sv | 17 +
 rtl/dbus_bridge_timer.sv | 32 +++
 rtl/dbus_slow_peri_bridge.sv | 129 ++++++++++++
 tb/tb_dbus_slow_peri_bridge.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_slow_peri_bridge_pkg.sv
// Shared definitions for the dbus slow-peripheral bridge: FSM state type and the
// default read data returned when a transfer is terminated by the watchdog.
`ifndef DBUS_BRIDGE_ERR_RDATA
`define DBUS_BRIDGE_ERR_RDATA 32'hDEADBEEF
`endif

package dbus_slow_peri_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } type_bridge_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/dbus_bridge_timer.sv
// Watchdog for the bridge REQ state; only built when DBUS_BRIDGE_TIMEOUT_EN is defined.
// The count equals the number of REQ cycles elapsed, including the current one.
`ifdef DBUS_BRIDGE_TIMEOUT_EN
module dbus_bridge_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    // Clear fires on the IDLE->REQ edge, so the first REQ cycle already reads 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= CW'(1);
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES));

endmodule
`endif

// File: rtl/dbus_slow_peri_bridge.sv
// Registered req/ack bridge between the dbus interconnect and one slow peripheral.
// Optional watchdog enabled by defining DBUS_BRIDGE_TIMEOUT_EN.
module dbus_slow_peri_bridge
    import dbus_slow_peri_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = DATA_WIDTH'(`DBUS_BRIDGE_ERR_RDATA)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel_i,
    input  logic                    dbus_req_i,
    input  logic                    dbus_w_en_i,
    input  logic [ADDR_WIDTH-1:0]   dbus_addr_i,
    input  logic [DATA_WIDTH-1:0]   dbus_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dbus_sel_byte_i,
    output logic [DATA_WIDTH-1:0]   dbus_rdata_o,
    output logic                    dbus_ack_o,
    output logic                    dbus_err_o,
    output logic                    p_req_o,
    output logic                    p_we_o,
    output logic [ADDR_WIDTH-1:0]   p_addr_o,
    output logic [DATA_WIDTH-1:0]   p_wdata_o,
    output logic [DATA_WIDTH/8-1:0] p_be_o,
    input  logic [DATA_WIDTH-1:0]   p_rdata_i,
    input  logic                    p_ack_i,
    output logic                    busy_o
);

    type_bridge_state_e state_q, state_d;

    logic                    start;
    logic                    timeout;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] be_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    assign start = (state_q == IDLE) && sel_i && dbus_req_i;

`ifdef DBUS_BRIDGE_TIMEOUT_EN
    logic err_q;

    dbus_bridge_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .enable  (state_q == REQ),
        .expired (timeout)
    );

    // A peripheral ack in the expiry cycle wins, so err is only set when ack is absent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == REQ) begin
            err_q <= timeout && !p_ack_i;
        end
    end

    assign dbus_err_o = dbus_ack_o && err_q;
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign dbus_err_o = 1'b0;
    assign unused_cfg = ^{ERR_RDATA, (TIMEOUT_CYCLES > 0)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (p_ack_i || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                we_q    <= dbus_w_en_i;
                addr_q  <= dbus_addr_i;
                wdata_q <= dbus_wdata_i;
                be_q    <= dbus_sel_byte_i;
            end
            if (state_q == REQ) begin
                if (p_ack_i) begin
                    rdata_q <= we_q ? '0 : p_rdata_i;
                end
`ifdef DBUS_BRIDGE_TIMEOUT_EN
                else if (timeout) begin
                    rdata_q <= ERR_RDATA;
                end
`endif
            end
        end
    end

    assign p_req_o      = (state_q == REQ);
    assign p_we_o       = we_q;
    assign p_addr_o     = addr_q;
    assign p_wdata_o    = wdata_q;
    assign p_be_o       = be_q;
    assign dbus_ack_o   = (state_q == RESP);
    assign dbus_rdata_o = dbus_ack_o ? rdata_q : '0;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_dbus_slow_peri_bridge.sv
// Self-checking bench for dbus_slow_peri_bridge: vector table, corner sequences and
// randomized transfers against a latency/response model.
module tb_dbus_slow_peri_bridge;

    localparam int          TO_CYC = 4;
    localparam logic [31:0] ERR_RD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, req, w_en;
    logic [31:0] addr_in, wdata_in;
    logic [3:0]  be_in;
    logic [31:0] dbus_rdata;
    logic        dbus_ack, dbus_err;
    logic        p_req, p_we;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_be;
    logic [31:0] p_rdata;
    logic        p_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    dbus_slow_peri_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sel_i          (sel),
        .dbus_req_i     (req),
        .dbus_w_en_i    (w_en),
        .dbus_addr_i    (addr_in),
        .dbus_wdata_i   (wdata_in),
        .dbus_sel_byte_i(be_in),
        .dbus_rdata_o   (dbus_rdata),
        .dbus_ack_o     (dbus_ack),
        .dbus_err_o     (dbus_err),
        .p_req_o        (p_req),
        .p_we_o         (p_we),
        .p_addr_o       (p_addr),
        .p_wdata_o      (p_wdata),
        .p_be_o         (p_be),
        .p_rdata_i      (p_rdata),
        .p_ack_i        (p_ack),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          wait_n;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response model: ack follows the peripheral ack by one cycle; with the watchdog,
    // a transfer not acked within TO_CYC REQ cycles ends with the error response.
    task automatic model(input logic we, input int wait_n, input logic [31:0] prdata,
                         output logic [31:0] rd, output logic er, output int lat);
`ifdef DBUS_BRIDGE_TIMEOUT_EN
        if (wait_n >= TO_CYC) begin
            rd  = ERR_RD;
            er  = 1'b1;
            lat = TO_CYC + 1;
            return;
        end
`endif
        rd  = we ? 32'h0 : prdata;
        er  = 1'b0;
        lat = wait_n + 2;
    endtask

    // Presents one request right after a clock edge and acts as the peripheral, acking in
    // REQ cycle wait_n (0-based). Returns the response and the ack cycle relative to request.
    task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int wait_n, input logic [31:0] prdata,
                           output logic [31:0] rd, output logic er, output int lat);
        int nreq;
        bit done;
        nreq = 0; done = 0; rd = '0; er = 1'b0; lat = -1;
        sel = 1'b1; req = 1'b1; w_en = we; addr_in = addr; wdata_in = wdata; be_in = be;
        for (int c = 1; c <= 100 && !done; c++) begin
            tick();
            p_ack   = 1'b0;
            p_rdata = $urandom;
            if (dbus_ack) begin
                rd = dbus_rdata; er = dbus_err; lat = c; done = 1;
                sel = 1'b0; req = 1'b0;
                chk("p_req_low_at_ack", p_req, 1'b0);
            end else begin
                chk("rdata_zero_without_ack", dbus_rdata, 32'h0);
                if (p_req) begin
                    chk("p_fields_held", {p_we, p_addr, p_wdata, p_be}, {we, addr, wdata, be});
                    if (nreq == wait_n) begin
                        p_ack   = 1'b1;
                        p_rdata = prdata;
                    end
                    nreq++;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL xfer_no_ack: no dbus_ack within 100 cycles, expected one");
            sel = 1'b0; req = 1'b0; p_ack = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat, exp_lat;
        int          t1;

        rst = 1'b1; sel = 1'b0; req = 1'b0; w_en = 1'b0;
        addr_in = '0; wdata_in = '0; be_in = '0; p_rdata = '0; p_ack = 1'b0;

        vecs.push_back('{1'b0, 32'h0400_0008, 32'h0, 4'hF, 2, 32'h1234_5678, 32'h1234_5678, 1'b0, 4});
        vecs.push_back('{1'b1, 32'h0400_0010, 32'h0000_AB00, 4'b0010, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 3});
        vecs.push_back('{1'b0, 32'h0400_0020, 32'h0, 4'hF, 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 2});
        vecs.push_back('{1'b1, 32'h0400_0024, 32'h1111_2222, 4'hF, 0, 32'h0BAD_0BAD, 32'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h0400_0028, 32'h0, 4'hF, 5, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 7});
`ifdef DBUS_BRIDGE_TIMEOUT_EN
        vecs.push_back('{1'b0, 32'h0400_0030, 32'h0, 4'hF, 1000, 32'h5555_5555, ERR_RD, 1'b1, 5});
        vecs.push_back('{1'b0, 32'h0400_0034, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 5});
        vecs.push_back('{1'b1, 32'h0400_0038, 32'h7777_0000, 4'b1100, 1000, 32'h0, ERR_RD, 1'b1, 5});
`endif

        // reset state
        tick(); tick();
        chk("reset_outputs", {dbus_rdata, dbus_ack, dbus_err, p_req, p_we, p_addr, p_wdata, p_be, busy}, '0);
        rst = 1'b0;
        tick();
        chk("post_reset_idle", {dbus_ack, p_req, busy}, 3'b000);

        // peripheral ack and partial selects while idle must not start anything
        p_ack = 1'b1; p_rdata = 32'h9999_9999; sel = 1'b1; req = 1'b0;
        tick();
        chk("idle_sel_only", {busy, dbus_ack, p_req}, 3'b000);
        sel = 1'b0; req = 1'b1;
        tick();
        chk("idle_req_only", {busy, dbus_ack, p_req}, 3'b000);
        p_ack = 1'b0; req = 1'b0;
        tick();

        // vector table
        foreach (vecs[i]) begin
            do_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].wait_n,
                    vecs[i].prdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            tick();
        end

        // async reset while the peripheral request is outstanding
        sel = 1'b1; req = 1'b1; w_en = 1'b0; addr_in = 32'h0400_0040; be_in = 4'hF;
        tick();
        chk("rst_seq_p_req_up", p_req, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_seq_p_req_drop", {p_req, busy, dbus_ack}, 3'b000);
        sel = 1'b0; req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_seq_no_ack", dbus_ack, 1'b0);
        end
        rst = 1'b0;
        tick();
        do_xfer(1'b0, 32'h0400_0044, 32'h0, 4'hF, 1, 32'h600D_D00D, rd, er, lat);
        chk("rst_seq_after_rdata", rd, 32'h600D_D00D);
        chk("rst_seq_after_lat", lat, 3);
        tick();

        // back-to-back loads, second presented the cycle after the first ack
        do_xfer(1'b0, 32'h0400_0050, 32'h0, 4'hF, 0, 32'h1111_1111, rd, er, lat);
        chk("b2b_first_rdata", rd, 32'h1111_1111);
        t1 = cyc_cnt;
        tick();
        do_xfer(1'b0, 32'h0400_0054, 32'h0, 4'hF, 0, 32'h2222_2222, rd, er, lat);
        chk("b2b_second_rdata", rd, 32'h2222_2222);
        chk("b2b_ack_spacing", cyc_cnt - t1, 3);
        tick();

        // randomized transfers against the model
        for (int n = 0; n < 60; n++) begin
            logic        r_we;
            logic [31:0] r_addr, r_wdata, r_prd;
            logic [3:0]  r_be;
            int          r_wait;
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_be    = 4'($urandom_range(0, 15));
            r_prd   = $urandom;
            r_wait  = $urandom_range(0, 6);
            do_xfer(r_we, r_addr, r_wdata, r_be, r_wait, r_prd, rd, er, lat);
            model(r_we, r_wait, r_prd, exp_rd, exp_er, exp_lat);
            chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
            chk($sformatf("rnd%0d_err", n), er, exp_er);
            chk($sformatf("rnd%0d_latency", n), lat, exp_lat);
            repeat (1 + $urandom_range(0, 2)) tick();
            chk("rnd_idle_after_ack", {busy, dbus_ack}, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
